// File: rtl/wager_ledger.sv
// wager_ledger: bankroll and wager bookkeeping behind the baccarat sequencer.
// A bet is latched on load_wager and its stake is deducted from the balance at
// once. The bet is settled on the next nonzero result, and the credit is added
// back with saturation. Once the balance settles at zero, the ledger locks up
// in BROKE until resetb.
module wager_ledger #(
    parameter int BAL_W        = 12,
    parameter int INIT_BALANCE = 100,
    parameter int TIE_ODDS     = 8
) (
    input  logic             slow_clock,
    input  logic             resetb,
    input  logic             load_wager,
    input  logic [1:0]       bet_in,
    input  logic [7:0]       amount_in,
    input  logic [1:0]       result,
    output logic [BAL_W-1:0] balance,
    output logic [7:0]       stake,
    output logic [1:0]       bet_side,
    output logic             win,
    output logic             lose,
    output logic             push,
    output logic             broke,
    output logic [7:0]       hands_played
);

    // Settlement arithmetic uses four guard bits so that the largest tie payout
    // added to a full balance cannot wrap before the saturation test.
    localparam int SUM_W = BAL_W + 4;
    localparam logic [BAL_W-1:0] BAL_MAX  = {BAL_W{1'b1}};
    localparam logic [BAL_W-1:0] BAL_INIT = BAL_W'(INIT_BALANCE);
    localparam logic [SUM_W-1:0] TIE_MULT = SUM_W'(TIE_ODDS + 1);

    localparam logic [1:0] SIDE_NONE   = 2'b00;
    localparam logic [1:0] SIDE_TIE    = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ARMED = 2'b01,
        BROKE = 2'b10
    } state_t;

    state_t state_reg;

    logic [SUM_W-1:0] amount_ext;
    logic [SUM_W-1:0] balance_ext;
    logic [SUM_W-1:0] stake_ext;
    logic [SUM_W-1:0] commit_ext;
    logic [7:0]       commit_next;
    logic [SUM_W-1:0] credit_next;
    logic [SUM_W-1:0] sum_next;
    logic [BAL_W-1:0] settled_next;
    logic             win_next;
    logic             lose_next;
    logic             push_next;

    // Stake to commit on an accepted wager: the request is capped at the
    // current bankroll, and a "no bet" side always commits nothing.
    always_comb begin
        amount_ext  = SUM_W'(amount_in);
        balance_ext = SUM_W'(balance);
        commit_ext  = '0;
        if (bet_in != SIDE_NONE) begin
            commit_ext = (amount_ext < balance_ext) ? amount_ext : balance_ext;
        end
        // The committed stake never exceeds amount_in, so it fits in 8 bits.
        commit_next = commit_ext[7:0];
    end

    // Settlement credit and outcome flags for the latched bet against result.
    always_comb begin
        stake_ext   = SUM_W'(stake);
        credit_next = '0;
        win_next    = 1'b0;
        lose_next   = 1'b0;
        push_next   = 1'b0;
        if (bet_side == SIDE_NONE) begin
            // No bet placed: hand counts, but nothing is won or lost.
            credit_next = '0;
        end else if (bet_side == SIDE_TIE) begin
            if (result == SIDE_TIE) begin
                credit_next = stake_ext * TIE_MULT;
                win_next    = 1'b1;
            end else begin
                lose_next = 1'b1;
            end
        end else if (bet_side == result) begin
            credit_next = stake_ext + stake_ext;
            win_next    = 1'b1;
        end else if (result == SIDE_TIE) begin
            // A player/dealer bet on a tied hand is refunded.
            credit_next = stake_ext;
            push_next   = 1'b1;
        end else begin
            lose_next = 1'b1;
        end
        sum_next     = balance_ext + credit_next;
        settled_next = (sum_next > SUM_W'(BAL_MAX)) ? BAL_MAX : sum_next[BAL_W-1:0];
    end

    // Ledger state machine: accept a wager in IDLE, settle it in ARMED, and lock
    // up in BROKE. All outputs are registered here.
    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            state_reg    <= IDLE;
            balance      <= BAL_INIT;
            stake        <= 8'd0;
            bet_side     <= 2'b00;
            win          <= 1'b0;
            lose         <= 1'b0;
            push         <= 1'b0;
            broke        <= 1'b0;
            hands_played <= 8'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // A result seen here has no bet behind it and is dropped.
                    // When load_wager and result arrive together, the wager wins.
                    if (load_wager) begin
                        stake     <= commit_next;
                        bet_side  <= bet_in;
                        balance   <= balance - BAL_W'(commit_ext);
                        win       <= 1'b0;
                        lose      <= 1'b0;
                        push      <= 1'b0;
                        state_reg <= ARMED;
                    end
                end
                ARMED: begin
                    // A repeated load_wager is ignored; only the result matters.
                    if (result != 2'b00) begin
                        balance <= settled_next;
                        win     <= win_next;
                        lose    <= lose_next;
                        push    <= push_next;
                        if (hands_played != 8'hFF) begin
                            hands_played <= hands_played + 8'd1;
                        end
                        if (settled_next == '0) begin
                            broke     <= 1'b1;
                            state_reg <= BROKE;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
                end
                BROKE: begin
                    // Everything holds until the next reset.
                    state_reg <= BROKE;
                end
                default: begin
                    // An illegal state code falls back to IDLE.
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wager_ledger.sv
// tb_wager_ledger: two ledgers share one stimulus stream. One uses the default
// parameters. The other uses an 8-bit balance starting at 250 so that payout
// saturation is exercised. Each ledger is tracked by an integer-level model of
// the betting rules, and both are compared on every falling edge. Directed
// hand-computed checks pin the model.
module tb_wager_ledger;

    typedef struct {
        int bal;
        int stake;
        int side;
        int armed;
        int broke;
        int win;
        int lose;
        int push;
        int hands;
    } mstate_t;

    localparam int TIE = 8;

    logic        slow_clock;
    logic        resetb;
    logic        load_wager;
    logic [1:0]  bet_in;
    logic [7:0]  amount_in;
    logic [1:0]  result;

    logic [11:0] bal0;
    logic [7:0]  stake0;
    logic [1:0]  side0;
    logic        win0, lose0, push0, broke0;
    logic [7:0]  hands0;

    logic [7:0]  bal1;
    logic [7:0]  stake1;
    logic [1:0]  side1;
    logic        win1, lose1, push1, broke1;
    logic [7:0]  hands1;

    int errors = 0;
    int checks = 0;
    bit cmp_on = 0;

    mstate_t m0, m1;

    wager_ledger u_main (
        .slow_clock  (slow_clock),
        .resetb      (resetb),
        .load_wager  (load_wager),
        .bet_in      (bet_in),
        .amount_in   (amount_in),
        .result      (result),
        .balance     (bal0),
        .stake       (stake0),
        .bet_side    (side0),
        .win         (win0),
        .lose        (lose0),
        .push        (push0),
        .broke       (broke0),
        .hands_played(hands0)
    );

    wager_ledger #(.BAL_W(8), .INIT_BALANCE(250), .TIE_ODDS(TIE)) u_sat (
        .slow_clock  (slow_clock),
        .resetb      (resetb),
        .load_wager  (load_wager),
        .bet_in      (bet_in),
        .amount_in   (amount_in),
        .result      (result),
        .balance     (bal1),
        .stake       (stake1),
        .bet_side    (side1),
        .win         (win1),
        .lose        (lose1),
        .push        (push1),
        .broke       (broke1),
        .hands_played(hands1)
    );

    initial slow_clock = 1'b0;
    always #5 slow_clock = ~slow_clock;

    function automatic mstate_t fresh(int init);
        mstate_t s;
        s.bal = init; s.stake = 0; s.side = 0; s.armed = 0; s.broke = 0;
        s.win = 0; s.lose = 0; s.push = 0; s.hands = 0;
        return s;
    endfunction

    // One clock of the betting rules, written in terms of the bankroll.
    function automatic mstate_t step(mstate_t s, bit lw, int bet, int amt, int res, int maxb);
        mstate_t n;
        int credit;
        n = s;
        if (s.broke != 0) return n;
        if (s.armed == 0) begin
            if (lw) begin
                n.side  = bet;
                n.stake = (bet == 0) ? 0 : ((amt < s.bal) ? amt : s.bal);
                n.bal   = s.bal - n.stake;
                n.win = 0; n.lose = 0; n.push = 0;
                n.armed = 1;
            end
        end else if (res != 0) begin
            credit = 0;
            n.win = 0; n.lose = 0; n.push = 0;
            if (s.side == 0) begin
                credit = 0;
            end else if (s.side == 3) begin
                if (res == 3) begin credit = (TIE + 1) * s.stake; n.win = 1; end
                else n.lose = 1;
            end else if (s.side == res) begin
                credit = 2 * s.stake; n.win = 1;
            end else if (res == 3) begin
                credit = s.stake; n.push = 1;
            end else begin
                n.lose = 1;
            end
            n.bal   = (s.bal + credit > maxb) ? maxb : s.bal + credit;
            n.hands = (s.hands < 255) ? s.hands + 1 : 255;
            n.armed = 0;
            if (n.bal == 0) n.broke = 1;
        end
        return n;
    endfunction

    // Models advance on the same edges as the designs.
    always @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            m0 <= fresh(100);
            m1 <= fresh(250);
        end else begin
            m0 <= step(m0, load_wager, int'(bet_in), int'(amount_in), int'(result), 4095);
            m1 <= step(m1, load_wager, int'(bet_in), int'(amount_in), int'(result), 255);
        end
    end

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of both designs against their models.
    always @(negedge slow_clock) begin
        if (cmp_on && resetb) begin
            chk("main.balance", int'(bal0),   m0.bal);
            chk("main.stake",   int'(stake0), m0.stake);
            chk("main.side",    int'(side0),  m0.side);
            chk("main.win",     int'(win0),   m0.win);
            chk("main.lose",    int'(lose0),  m0.lose);
            chk("main.push",    int'(push0),  m0.push);
            chk("main.broke",   int'(broke0), m0.broke);
            chk("main.hands",   int'(hands0), m0.hands);
            chk("sat.balance",  int'(bal1),   m1.bal);
            chk("sat.stake",    int'(stake1), m1.stake);
            chk("sat.side",     int'(side1),  m1.side);
            chk("sat.win",      int'(win1),   m1.win);
            chk("sat.lose",     int'(lose1),  m1.lose);
            chk("sat.push",     int'(push1),  m1.push);
            chk("sat.broke",    int'(broke1), m1.broke);
            chk("sat.hands",    int'(hands1), m1.hands);
        end
    end

    task automatic do_reset();
        @(negedge slow_clock);
        #1;
        resetb = 1'b0;
        load_wager = 1'b0; bet_in = 2'b00; amount_in = 8'd0; result = 2'b00;
        #2;
        resetb = 1'b1;
    endtask

    task automatic pulse(bit lw, logic [1:0] bet, logic [7:0] amt, logic [1:0] res);
        @(negedge slow_clock);
        load_wager = lw; bet_in = bet; amount_in = amt; result = res;
        @(negedge slow_clock);
        load_wager = 1'b0; result = 2'b00;
    endtask

    initial begin
        resetb = 1'b1;
        load_wager = 1'b0; bet_in = 2'b00; amount_in = 8'd0; result = 2'b00;

        // Reset state
        do_reset();
        cmp_on = 1;
        chk("rst.balance", int'(bal0), 100);
        chk("rst.stake",   int'(stake0), 0);
        chk("rst.flags",   int'({win0, lose0, push0, broke0}), 0);
        chk("rst.hands",   int'(hands0), 0);
        chk("rst.sat_bal", int'(bal1), 250);

        // Player bet 20, player wins
        pulse(1, 2'b01, 8'd20, 2'b00);
        chk("t1.bal_after_wager", int'(bal0), 80);
        chk("t1.stake",           int'(stake0), 20);
        pulse(0, 2'b00, 8'd0, 2'b01);
        chk("t1.bal_after_win", int'(bal0), 120);
        chk("t1.win",           int'(win0), 1);
        chk("t1.hands",         int'(hands0), 1);

        // Dealer bet on a tie is refunded
        do_reset();
        pulse(1, 2'b10, 8'd30, 2'b00);
        pulse(0, 2'b00, 8'd0, 2'b11);
        chk("t2.push",    int'(push0), 1);
        chk("t2.balance", int'(bal0), 100);
        chk("t2.lose",    int'(lose0), 0);

        // Winning tie bet
        do_reset();
        pulse(1, 2'b11, 8'd10, 2'b00);
        pulse(0, 2'b00, 8'd0, 2'b11);
        chk("t3.balance", int'(bal0), 180);
        chk("t3.win",     int'(win0), 1);

        // Stake clamped to bankroll, lose, then locked out
        do_reset();
        pulse(1, 2'b01, 8'd200, 2'b00);
        chk("t4.stake",   int'(stake0), 100);
        chk("t4.balance", int'(bal0), 0);
        chk("t4.broke_early", int'(broke0), 0);
        pulse(0, 2'b00, 8'd0, 2'b10);
        chk("t4.lose",  int'(lose0), 1);
        chk("t4.broke", int'(broke0), 1);
        pulse(1, 2'b01, 8'd50, 2'b01);
        chk("t4.locked_bal",   int'(bal0), 0);
        chk("t4.locked_broke", int'(broke0), 1);
        chk("t4.locked_hands", int'(hands0), 1);

        // Saturation on the 8-bit ledger, ignored re-wager, mid-hand reset
        do_reset();
        pulse(1, 2'b11, 8'd200, 2'b00);
        chk("t5.sat_bal_wager", int'(bal1), 50);
        pulse(1, 2'b01, 8'd10, 2'b00);
        chk("t5.sat_stake_hold", int'(stake1), 200);
        chk("t5.sat_bal_hold",   int'(bal1), 50);
        pulse(0, 2'b00, 8'd0, 2'b11);
        chk("t5.sat_bal_max", int'(bal1), 255);
        chk("t5.sat_win",     int'(win1), 1);
        chk("t5.main_bal",    int'(bal0), 900);
        pulse(1, 2'b01, 8'd5, 2'b00);
        chk("t5.sat_rearmed", int'(bal1), 250);
        do_reset();
        chk("t5.rst_bal",   int'(bal1), 250);
        chk("t5.rst_flags", int'({win1, lose1, push1, broke1}), 0);
        chk("t5.rst_hands", int'(hands1), 0);

        // Result without a wager, then simultaneous wager and result in IDLE
        do_reset();
        pulse(0, 2'b00, 8'd0, 2'b01);
        chk("t6.idle_bal",   int'(bal0), 100);
        chk("t6.idle_hands", int'(hands0), 0);
        pulse(1, 2'b01, 8'd5, 2'b10);
        chk("t6.both_bal",   int'(bal0), 95);
        chk("t6.both_stake", int'(stake0), 5);
        chk("t6.both_hands", int'(hands0), 0);
        pulse(0, 2'b00, 8'd0, 2'b01);
        chk("t6.armed_bal", int'(bal0), 105);
        chk("t6.armed_win", int'(win0), 1);

        // Randomized play with occasional resets
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 249) == 0) begin
                do_reset();
            end else begin
                @(negedge slow_clock);
                load_wager = ($urandom_range(0, 3) == 0);
                bet_in     = 2'($urandom_range(0, 3));
                amount_in  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                         : 8'($urandom_range(0, 40));
                result     = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            end
        end
        @(negedge slow_clock);
        load_wager = 1'b0; result = 2'b00;
        @(negedge slow_clock);
        cmp_on = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wager_ledger.md
Name: wager_ledger

Overview:
- Bankroll and wager bookkeeping stage directly downstream of the baccarat game sequencer.
- Latches the player's bet (side and amount) on the sequencer's one-cycle load_wager pulse.
- Settles the bet on the sequencer's one-cycle result pulse, updates a saturating balance, and raises win/lose/push indicators and a broke flag for the display logic.

Parameters:
- BAL_W, 12, balance register width in bits.
- INIT_BALANCE, 100, balance loaded on reset; must be less than 2^BAL_W.
- TIE_ODDS, 8, winnings multiple for a successful tie bet; a winning tie credits stake*(TIE_ODDS+1).

Ports:
- slow_clock  in  1  game clock; all state updates on its rising edge.
- resetb  in  1  asynchronous, active-low reset.
- load_wager  in  1  one-cycle pulse from the sequencer: latch the bet now.
- bet_in  in  2  bet side: 00 none, 01 player, 10 dealer, 11 tie.
- amount_in  in  8  requested stake, from the switches.
- result  in  2  sequencer outcome: 00 none, 01 player wins, 10 dealer wins, 11 tie; nonzero for one cycle.
- balance  out  BAL_W  current bankroll.
- stake  out  8  stake actually committed for the current hand.
- bet_side  out  2  latched bet_in.
- win  out  1  last hand won.
- lose  out  1  last hand lost.
- push  out  1  last hand refunded.
- broke  out  1  balance reached 0; betting is locked out.
- hands_played  out  8  settled hand count; saturates at 255.

Behaviour:
- Reset (async, resetb=0) forces:
  - balance=INIT_BALANCE
  - stake=0, bet_side=00
  - win=lose=push=0, broke=0
  - hands_played=0
  - state IDLE
- States: IDLE, ARMED, BROKE.
- IDLE, load_wager=1:
  - stake <= min(amount_in, balance), zero-extended for the comparison.
  - bet_side <= bet_in.
  - balance <= balance - committed stake, deducted in the same edge.
  - win/lose/push cleared.
  - Next state ARMED.
  - bet_in=00 commits stake 0 regardless of amount_in.
- IDLE, result nonzero without a prior wager: ignored; no register changes.
- ARMED, load_wager=1: ignored. Stake, bet_side and balance are unchanged.
- ARMED, result nonzero: settle in that edge and return to IDLE. Credit rules:
  - bet_side 00: credit 0; win=lose=push=0.
  - bet_side 01 or 10 matching result: credit 2*stake; win=1.
  - bet_side 01 or 10, result 11: credit stake; push=1.
  - bet_side 11, result 11: credit (TIE_ODDS+1)*stake; win=1.
  - Any other combination: credit 0; lose=1.
  - balance <= balance + credit. Compute in BAL_W+4 bits; saturate at 2^BAL_W-1.
  - hands_played increments, saturating at 255.
  - If the new balance equals 0, go to BROKE and set broke=1. Otherwise go to IDLE.
- BROKE: all of load_wager and result are ignored. Outputs hold until resetb.
- Latency:
  - Outputs are registered and valid on the edge after the pulse is sampled.
  - Indicators remain stable until the next accepted load_wager or reset.
- load_wager and result nonzero in the same cycle:
  - In IDLE, the wager is accepted and result is ignored.
  - In ARMED, result settles and load_wager is ignored.
- Reset mid-hand (ARMED): the committed stake is discarded. Balance returns to INIT_BALANCE.
- Invalid state encoding: recover to IDLE on the next edge.

Test Plan:
- Reset, then load_wager with bet_in=01 and amount_in=20, then result=01 -> after the wager, balance=80 and stake=20. After the result, balance=120, win=1, hands_played=1.
- From reset: bet_in=10, amount_in=30, result=11 -> push=1, balance=100, lose=0.
- From reset: bet_in=11, amount_in=10, result=11 -> balance=90+90=180, win=1.
- From reset: bet_in=01, amount_in=200 -> stake clamped to 100, balance=0. Then result=10 -> lose=1, broke=1. A further load_wager with result=01 leaves balance=0 and broke=1.
- Saturation with BAL_W=8 and INIT_BALANCE=250:
  - bet 11, stake 200, result 11: the 1800 credit saturates balance at 255.
  - Then a second load_wager while ARMED is ignored: stake stays 200.
  - Then resetb pulsed low while ARMED: balance=250, all flags 0, hands_played=0.
- From reset, result=01 with no wager -> no change: balance=100, hands_played=0. Then same-cycle load_wager (bet_in=01, amount_in=5) with result=10 in IDLE -> wager accepted (balance=95, stake=5), state ARMED, result ignored.
